// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the button/switch/LED I/O controller.
// Holds the bus word offsets, button bit indices, the debounce state
// encoding, CTRL register field positions and the pending-bit priority
// encoder used to build the CTRL read value.
package io_ctrl_pkg;

    // Bus word offsets
    localparam logic [1:0] ADDR_SW   = 2'd0;
    localparam logic [1:0] ADDR_BTN  = 2'd1;
    localparam logic [1:0] ADDR_LED  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    // Button bit order used in every button-wide vector
    localparam int BTN_U   = 0;
    localparam int BTN_D   = 1;
    localparam int BTN_L   = 2;
    localparam int BTN_R   = 3;
    localparam int NUM_BTN = 4;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // accepted low
        CHK_H = 2'd1,   // qualifying a rise
        HIGH  = 2'd2,   // accepted high
        CHK_L = 2'd3    // qualifying a fall
    } db_state_t;

    // CTRL word field positions
    localparam int CTRL_IRQ_EN_BIT = 0;
    localparam int CTRL_IDX_LSB    = 4;
    localparam int CTRL_ANY_BIT    = 7;

    // Index of the lowest-numbered set bit; 0 when nothing is set.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser followed by a debounce
// FSM. A level change is accepted only after DEBOUNCE_CYCLES consecutive
// synchronised samples at the new level. Accepting a rise produces a
// registered one-cycle press pulse; accepting a fall produces nothing.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   btn          : raw (asynchronous, bouncy) button input
//   press_pulse  : one-cycle pulse when a press is accepted
//   level        : current accepted (debounced) level
module btn_debounce
    import io_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press_pulse,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0, sync_p1;
    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            // synchroniser stage boundary
            sync_p0     <= btn;
            sync_p1     <= sync_p0;
            // FSM stage boundary
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press_pulse <= pulse_nxt;
        end
    end

    // cnt counts samples seen at the candidate level, including the one
    // that triggered the CHK state; acceptance happens on the sample that
    // finds cnt already at DEBOUNCE_CYCLES-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync_p1) begin
                    state_nxt = CHK_H;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHK_H: begin
                if (!sync_p1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync_p1) begin
                    state_nxt = CHK_L;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHK_L: begin
                if (sync_p1) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level = (state == HIGH) || (state == CHK_L);

endmodule

// File: rtl/io_button_ctrl.sv
// Memory-mapped I/O controller for board switches, buttons and LEDs.
// Switches are synchronised only; buttons are synchronised and debounced,
// and accepted presses latch into a sticky pending register cleared by
// write-1-to-clear. A registered level irq is raised while irq_en and any
// pending bit are set.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   switches[15:0]      : raw slide switches
//   btn_u/d/l/r         : raw buttons (pend bit 0..3)
//   bus_addr[1:0]       : word select 0 SW, 1 BTN, 2 LED, 3 CTRL
//   bus_re, bus_we      : read / write strobes
//   bus_wdata[31:0]     : write data
//   bus_rdata[31:0]     : registered read data, held between reads
//   leds[15:0]          : LED drive register
//   irq                 : registered interrupt request
module io_button_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] switches,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic [1:0]  bus_addr,
    input  logic        bus_re,
    input  logic        bus_we,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [15:0] leds,
    output logic        irq
);

    logic [15:0]        sw_p0, sw_p1;
    logic [NUM_BTN-1:0] btn_raw, press, level;
    logic [NUM_BTN-1:0] pend;
    logic               irq_en;
    logic               wr_btn, wr_led, wr_ctrl;
    logic [31:0]        ctrl_word, rd_mux;

    assign btn_raw[BTN_U] = btn_u;
    assign btn_raw[BTN_D] = btn_d;
    assign btn_raw[BTN_L] = btn_l;
    assign btn_raw[BTN_R] = btn_r;

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk        (clk),
                .reset      (reset),
                .btn        (btn_raw[i]),
                .press_pulse(press[i]),
                .level      (level[i])
            );
        end
    endgenerate

    assign wr_btn  = bus_we && (bus_addr == ADDR_BTN);
    assign wr_led  = bus_we && (bus_addr == ADDR_LED);
    assign wr_ctrl = bus_we && (bus_addr == ADDR_CTRL);

    always_comb begin
        ctrl_word                           = '0;
        ctrl_word[CTRL_IRQ_EN_BIT]          = irq_en;
        ctrl_word[CTRL_IDX_LSB +: 2]        = lowest_set(pend);
        ctrl_word[CTRL_ANY_BIT]             = |pend;
    end

    always_comb begin
        rd_mux = '0;
        unique case (bus_addr)
            ADDR_SW:   rd_mux = {16'b0, sw_p1};
            ADDR_BTN:  rd_mux = {28'b0, pend};
            ADDR_LED:  rd_mux = {16'b0, leds};
            ADDR_CTRL: rd_mux = ctrl_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_p0     <= '0;
            sw_p1     <= '0;
            pend      <= '0;
            irq_en    <= 1'b0;
            leds      <= '0;
            irq       <= 1'b0;
            bus_rdata <= '0;
        end else begin
            // switch synchroniser stage boundary
            sw_p0 <= switches;
            sw_p1 <= sw_p0;
            // register file stage boundary; a press in the same cycle as
            // its W1C wins so no event can be lost
            if (wr_btn)
                pend <= (pend & ~bus_wdata[NUM_BTN-1:0]) | press;
            else
                pend <= pend | press;
            if (wr_led)
                leds <= bus_wdata[15:0];
            if (wr_ctrl)
                irq_en <= bus_wdata[CTRL_IRQ_EN_BIT];
            irq <= irq_en & (|pend);
            // rd_mux sees pre-write values, so read+write returns old data
            if (bus_re)
                bus_rdata <= rd_mux;
        end
    end

    // Accepted levels are not mapped to any register; upper write bits
    // have no destination.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus_wdata[31:16], level};

endmodule
